fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer sharing one memory port between
// instruction fetch and load/store data access, with a bus-ack timeout.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_value,
    output logic        pc_en,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        mem_is_load,
    input  logic        mem_is_store,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] load_data,
    output logic        load_valid,
    input  logic        halt,
    output logic        halted,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_DATA,
        S_COMMIT,
        S_HALTED
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        is_load_q;
    logic        is_store_q;
    logic        in_bus;
    logic        expire;

    assign in_bus = (state == S_FETCH) || (state == S_DATA);
    // No ack in the cycle the counter would reach TIMEOUT ends the access.
    assign expire = in_bus && !bus_ack && (wait_cnt == LAST_WAIT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: begin
                if (bus_ack) begin
                    state_next = S_EXEC;
                end else if (expire) begin
                    state_next = S_HALTED;
                end
            end
            S_EXEC: begin
                if (mem_is_load || mem_is_store) begin
                    state_next = S_DATA;
                end else begin
                    state_next = S_COMMIT;
                end
            end
            S_DATA: begin
                if (bus_ack) begin
                    state_next = S_COMMIT;
                end else if (expire) begin
                    state_next = S_HALTED;
                end
            end
            S_COMMIT: begin
                state_next = halt ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                if (!bus_error && !halt) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= 8'd0;
            instr      <= 32'd0;
            load_data  <= 32'd0;
            bus_error  <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
        end else begin
            if (in_bus && !bus_ack && !expire) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (expire) begin
                bus_error <= 1'b1;
            end
            if (state == S_FETCH && bus_ack) begin
                instr <= bus_rdata;
            end
            if (state == S_EXEC) begin
                addr_q     <= data_addr;
                wdata_q    <= data_wdata;
                is_load_q  <= mem_is_load;
                // Both flags set resolves to a load.
                is_store_q <= mem_is_store && !mem_is_load;
            end
            if (state == S_DATA && bus_ack && is_load_q) begin
                load_data <= bus_rdata;
            end
        end
    end

    // Reset gates the request so it drops without waiting for a clock edge.
    always_comb begin
        bus_req   = in_bus && reset;
        bus_we    = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
        if (bus_req) begin
            if (state == S_DATA) begin
                bus_we    = is_store_q;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
            end else begin
                bus_addr = pc_value;
            end
        end
    end

    assign instr_valid = (state == S_EXEC);
    assign pc_en       = (state == S_COMMIT);
    assign load_valid  = (state == S_COMMIT) && is_load_q;
    assign halted      = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer; each instruction is planned up front
// and the expected per-cycle bus activity is derived from that plan.
module tb_fetch_sequencer;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_value = '0;
    logic        pc_en;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_is_load = 1'b0;
    logic        mem_is_store = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] load_data;
    logic        load_valid;
    logic        halt = 1'b0;
    logic        halted;
    logic        bus_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ld = '0;

    fetch_sequencer #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .pc_value(pc_value),
        .pc_en(pc_en), .instr(instr), .instr_valid(instr_valid),
        .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .load_data(load_data), .load_valid(load_valid),
        .halt(halt), .halted(halted), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic req,
                             input logic we, input logic [31:0] addr,
                             input logic [31:0] wd);
        check_eq({tag, "_req"}, 32'(bus_req), 32'(req));
        check_eq({tag, "_we"}, 32'(bus_we), 32'(we));
        check_eq({tag, "_addr"}, bus_addr, addr);
        check_eq({tag, "_wdata"}, bus_wdata, wd);
    endtask

    task automatic check_ctl(input string tag, input logic iv,
                             input logic pe, input logic lv,
                             input logic hl, input logic er);
        check_eq({tag, "_ivalid"}, 32'(instr_valid), 32'(iv));
        check_eq({tag, "_pc_en"}, 32'(pc_en), 32'(pe));
        check_eq({tag, "_lvalid"}, 32'(load_valid), 32'(lv));
        check_eq({tag, "_halted"}, 32'(halted), 32'(hl));
        check_eq({tag, "_err"}, 32'(bus_error), 32'(er));
    endtask

    // Asserts reset away from any clock edge and releases it at a negedge.
    task automatic do_reset();
        #1 reset = 1'b0;
        #1;
        check_bus("rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_ldata", load_data, 32'd0);
        exp_ld = '0;
        bus_ack = 1'b0;
        halt = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic timeout_seq(input string tag);
        for (int i = 0; i < 3; i++) begin
            halt = 1'b0;
            bus_ack = 1'($urandom);
            #1;
            check_bus({tag, "_to"}, 1'b0, 1'b0, 32'd0, 32'd0);
            check_ctl({tag, "_to"}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge clock);
        end
        do_reset();
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 load+store flags (acts as load)
    task automatic run_instr(input int kind, input logic [31:0] pc,
                             input logic [31:0] iw, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input int fd, input int dd, input bit hlt,
                             input int reset_at);
        bit mem = (kind != 0);
        bit ld = (kind == 1) || (kind == 3);
        bit st = (kind == 2);
        for (int k = 0; k < TMO; k++) begin
            pc_value = pc;
            bus_ack = (k == fd);
            bus_rdata = (k == fd) ? iw : $urandom;
            halt = 1'($urandom);
            #1;
            check_bus("fetch", 1'b1, 1'b0, pc, 32'd0);
            check_ctl("fetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clock);
            if (k == fd) break;
            if (k == TMO - 1) begin
                timeout_seq("fetch");
                return;
            end
        end
        bus_ack = 1'($urandom);
        bus_rdata = $urandom;
        halt = 1'($urandom);
        pc_value = $urandom;
        mem_is_load = ld;
        mem_is_store = st || (kind == 3);
        data_addr = addr;
        data_wdata = wd;
        #1;
        check_bus("exec", 1'b0, 1'b0, 32'd0, 32'd0);
        check_ctl("exec", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("exec_instr", instr, iw);
        @(negedge clock);
        mem_is_load = 1'($urandom);
        mem_is_store = 1'($urandom);
        data_addr = $urandom;
        data_wdata = $urandom;
        if (mem) begin
            for (int k = 0; k < TMO; k++) begin
                bus_ack = (k == dd);
                bus_rdata = (k == dd) ? rd : $urandom;
                halt = 1'($urandom);
                #1;
                check_bus("data", 1'b1, st, addr, wd);
                check_ctl("data", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                if (k == reset_at) begin
                    do_reset();
                    return;
                end
                @(negedge clock);
                if (k == dd) break;
                if (k == TMO - 1) begin
                    timeout_seq("data");
                    return;
                end
            end
        end
        bus_ack = 1'($urandom);
        bus_rdata = $urandom;
        halt = hlt;
        if (ld) exp_ld = rd;
        #1;
        check_bus("commit", 1'b0, 1'b0, 32'd0, 32'd0);
        check_ctl("commit", 1'b0, 1'b1, ld, 1'b0, 1'b0);
        check_eq("commit_ldata", load_data, exp_ld);
        @(negedge clock);
        if (hlt) begin
            int n = $urandom_range(0, 2);
            for (int i = 0; i <= n; i++) begin
                halt = (i < n);
                bus_ack = 1'($urandom);
                #1;
                check_bus("halt", 1'b0, 1'b0, 32'd0, 32'd0);
                check_ctl("halt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                @(negedge clock);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        run_instr(0, 32'h100, 32'h00500093, 0, 0, 0, 0, 0, 0, -1);
        run_instr(1, 32'h104, 32'h00002083, 32'h2000, 32'h0,
                  32'hDEADBEEF, 0, 3, 0, -1);
        run_instr(2, 32'h108, 32'h00102023, 32'h3000, 32'h12345678,
                  32'h0, 1, 0, 0, -1);
        run_instr(0, 32'h10C, 32'h00000013, 0, 0, 0, 0, 0, 1, -1);
        run_instr(3, 32'h200, 32'h11111111, 32'h44, 32'h55,
                  32'hCAFEF00D, TMO - 1, TMO - 1, 0, -1);
        run_instr(0, 32'h300, 32'h0, 0, 0, 0, TMO, 0, 0, -1);
        run_instr(2, 32'h400, 32'h22222222, 32'h80, 32'h99,
                  32'h0, 0, TMO, 0, -1);
        run_instr(1, 32'h500, 32'h33333333, 32'h90, 32'h0,
                  32'h77, 0, 3, 0, 1);
        for (int t = 0; t < 200; t++) begin
            int kind = $urandom_range(0, 3);
            int fd = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
            int dd = ($urandom_range(0, 9) == 0) ? TMO : $urandom_range(0, TMO - 1);
            int lim = (dd < TMO - 1) ? dd : TMO - 1;
            int ra = ($urandom_range(0, 14) == 0) ? $urandom_range(0, lim) : -1;
            run_instr(kind, $urandom, $urandom, $urandom, $urandom, $urandom,
                      fd, dd, ($urandom_range(0, 3) == 0), ra);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
